// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter unit for the pipelined MIPS core. Owns the F-stage PC
// register and picks the next fetch address from sequential fetch, a D-stage
// branch/jump/jr decision (one architectural delay slot), a stall hold, or a
// flush redirect (exception entry, eret).
//
// Optional build macro: PC_RANGE_CHECK_EN
//   When defined, every non-reset, non-flush, non-stall update checks the
//   candidate PC for misalignment and for lying outside [IMEM_BASE,IMEM_LIMIT].
//   A faulty candidate is replaced by EXC_VEC, and pc_exc is raised for one
//   cycle. When undefined, pc_exc is tied low and the window is not checked.
//
// Ports:
//   clk       in   clock, rising-edge active
//   reset     in   synchronous active-high reset (overrides flush and stall)
//   stall     in   hold F_pc
//   flush     in   redirect F_pc to flush_pc (wins over stall)
//   flush_pc  in   redirect target
//   npc_sel   in   0=PC4 1=BRANCH 2=JUMP 3=JR, 4..7 reserved (act as PC4)
//   cmp_op    in   0 EQ 1 NE 2 LEZ 3 GTZ 4 LTZ 5 GEZ, 6..7 never taken
//   D_pc      in   PC of the D-stage instruction
//   imm26     in   instr[25:0] of the D-stage instruction
//   rs_val    in   forwarded rs value
//   rt_val    in   forwarded rt value
//   F_pc      out  registered fetch PC
//   D_pc8     out  link address D_pc+8
//   br_taken  out  D-stage control transfer taken this cycle
//   sel_err   out  reserved npc_sel seen this cycle
//   pc_exc    out  registered fetch-address fault flag
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [2:0]  npc_sel,
  input  logic [2:0]  cmp_op,
  input  logic [31:0] D_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc8,
  output logic        br_taken,
  output logic        sel_err,
  output logic        pc_exc
);

  typedef enum logic [2:0] {
    SEL_PC4    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3
  } npc_sel_e;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LEZ = 3'd2,
    CMP_GTZ = 3'd3,
    CMP_LTZ = 3'd4,
    CMP_GEZ = 3'd5
  } cmp_op_e;

  // Fetch-window parameters must describe a sane, aligned window even when
  // the range check is compiled out, so a bad instantiation is caught early.
  if ((IMEM_BASE > IMEM_LIMIT) || (EXC_VEC[1:0] != 2'b00)) begin : g_param_check
    $error("pc_fetch_unit: inconsistent fetch window parameters");
  end

  // Branch condition; rt only participates in EQ/NE, zero compares are signed.
  function automatic logic branch_cond(
    input logic [2:0]         op,
    input logic signed [31:0] rs,
    input logic signed [31:0] rt
  );
    logic taken;
    taken = 1'b0;
    case (op)
      CMP_EQ:  taken = (rs == rt);
      CMP_NE:  taken = (rs != rt);
      CMP_LEZ: taken = (rs <= 32'sd0);
      CMP_GTZ: taken = (rs >  32'sd0);
      CMP_LTZ: taken = (rs <  32'sd0);
      CMP_GEZ: taken = (rs >= 32'sd0);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] br_off;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic [31:0]        xfer_target;
  logic [31:0]        seq_pc;
  logic [31:0]        cand_pc;
  logic [31:0]        upd_pc;

  assign rs_s = rs_val;
  assign rt_s = rt_val;

  // Decode stage: resolve the D-stage transfer and its target.
  always_comb begin
    br_taken    = 1'b0;
    sel_err     = 1'b0;
    xfer_target = 32'h0;
    br_off      = {{14{imm26[15]}}, imm26[15:0], 2'b00};
    br_target   = D_pc + 32'd4 + br_off;
    j_target    = {D_pc[31:28], imm26, 2'b00};
    case (npc_sel)
      SEL_PC4: begin
        br_taken = 1'b0;
      end
      SEL_BRANCH: begin
        br_taken    = branch_cond(cmp_op, rs_s, rt_s);
        xfer_target = br_target;
      end
      SEL_JUMP: begin
        br_taken    = 1'b1;
        xfer_target = j_target;
      end
      SEL_JR: begin
        br_taken    = 1'b1;
        xfer_target = rs_val;
      end
      default: begin
        sel_err = 1'b1;
      end
    endcase
  end

  assign D_pc8   = D_pc + 32'd8;
  assign seq_pc  = F_pc + 32'd4;
  assign cand_pc = br_taken ? xfer_target : seq_pc;

`ifdef PC_RANGE_CHECK_EN
  logic fault;

  assign fault  = (cand_pc[1:0] != 2'b00) || (cand_pc < IMEM_BASE) || (cand_pc > IMEM_LIMIT);
  assign upd_pc = fault ? EXC_VEC : cand_pc;

  // Fault flag is only produced by a normal update; flush, stall and reset
  // all clear it so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_exc <= 1'b0;
    end else if (flush || stall) begin
      pc_exc <= 1'b0;
    end else begin
      pc_exc <= fault;
    end
  end
`else
  assign upd_pc = cand_pc;
  assign pc_exc = 1'b0;
`endif

  // Fetch stage: PC register. The delay slot is already at F_pc, so a taken
  // transfer simply replaces the sequential F_pc+4; nothing is squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc <= RESET_PC;
    end else if (flush) begin
      F_pc <= flush_pc;
    end else if (!stall) begin
      F_pc <= upd_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  npc_sel;
  logic [2:0]  cmp_op;
  logic [31:0] D_pc;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] F_pc;
  logic [31:0] D_pc8;
  logic        br_taken;
  logic        sel_err;
  logic        pc_exc;

  pc_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .flush_pc (flush_pc),
    .npc_sel  (npc_sel),
    .cmp_op   (cmp_op),
    .D_pc     (D_pc),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .F_pc     (F_pc),
    .D_pc8    (D_pc8),
    .br_taken (br_taken),
    .sel_err  (sel_err),
    .pc_exc   (pc_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  sel;
    logic [2:0]  cmp;
    logic [31:0] dpc;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_bt;
    logic        exp_err;
    logic [31:0] exp_pc8;
    logic [31:0] exp_fpc;
    logic        exp_exc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] fpc;
    logic        exc;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string n, logic [2:0] sel, logic [2:0] cmp,
                              logic [31:0] dpc, logic [25:0] imm,
                              logic [31:0] rs, logic [31:0] rt,
                              logic bt, logic err, logic [31:0] pc8,
                              logic [31:0] fpc);
    vec_t v;
    v.name = n; v.reset = 1'b0; v.stall = 1'b0; v.flush = 1'b0;
    v.flush_pc = 32'h0; v.sel = sel; v.cmp = cmp; v.dpc = dpc; v.imm = imm;
    v.rs = rs; v.rt = rt; v.exp_bt = bt; v.exp_err = err; v.exp_pc8 = pc8;
    v.exp_fpc = fpc; v.exp_exc = 1'b0;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational outputs, queue the
  // expected registered result, then clock and compare against the queue head.
  task automatic apply(vec_t v);
    sb_t e;
    reset = v.reset; stall = v.stall; flush = v.flush; flush_pc = v.flush_pc;
    npc_sel = v.sel; cmp_op = v.cmp; D_pc = v.dpc; imm26 = v.imm;
    rs_val = v.rs; rt_val = v.rt;
    #1;
    chk({v.name, ".br_taken"}, {31'b0, br_taken}, {31'b0, v.exp_bt});
    chk({v.name, ".sel_err"},  {31'b0, sel_err},  {31'b0, v.exp_err});
    chk({v.name, ".D_pc8"},    D_pc8,             v.exp_pc8);
    e.name = v.name; e.fpc = v.exp_fpc; e.exc = v.exp_exc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, ".F_pc"},   F_pc,            e.fpc);
      chk({e.name, ".pc_exc"}, {31'b0, pc_exc}, {31'b0, e.exc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] dn;

    // Sweep region: branch at D_pc=3000 with offset 0x10 targets 3044.
    tbl.push_back(mk("seq0", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h3004));
    tbl.push_back(mk("seq1", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h3008));
    tbl.push_back(mk("seq2", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h300C));
    tbl.push_back(mk("beq_t", 3'd1, 3'd0, 32'h3008, 26'h000FFFE, 32'd5, 32'd5, 1'b1, 1'b0, 32'h3010, 32'h3004));
    tbl.push_back(mk("beq_n", 3'd1, 3'd0, 32'h3008, 26'h000FFFE, 32'd5, 32'd6, 1'b0, 1'b0, 32'h3010, 32'h3008));
    tbl.push_back(mk("bne_t", 3'd1, 3'd1, 32'h3008, 26'h000FFFE, 32'd5, 32'd6, 1'b1, 1'b0, 32'h3010, 32'h3004));
    tbl.push_back(mk("lez_m1", 3'd1, 3'd2, 32'h3000, 26'h10, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("lez_0",  3'd1, 3'd2, 32'h3000, 26'h10, 32'h0,         32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("lez_p1", 3'd1, 3'd2, 32'h3000, 26'h10, 32'h1,         32'd7, 1'b0, 1'b0, 32'h3008, 32'h3048));
    tbl.push_back(mk("gtz_m1", 3'd1, 3'd3, 32'h3000, 26'h10, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0, 32'h3008, 32'h304C));
    tbl.push_back(mk("gtz_0",  3'd1, 3'd3, 32'h3000, 26'h10, 32'h0,         32'd7, 1'b0, 1'b0, 32'h3008, 32'h3050));
    tbl.push_back(mk("gtz_p1", 3'd1, 3'd3, 32'h3000, 26'h10, 32'h1,         32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("ltz_m1", 3'd1, 3'd4, 32'h3000, 26'h10, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("ltz_0",  3'd1, 3'd4, 32'h3000, 26'h10, 32'h0,         32'd7, 1'b0, 1'b0, 32'h3008, 32'h3048));
    tbl.push_back(mk("ltz_p1", 3'd1, 3'd4, 32'h3000, 26'h10, 32'h1,         32'd7, 1'b0, 1'b0, 32'h3008, 32'h304C));
    tbl.push_back(mk("gez_m1", 3'd1, 3'd5, 32'h3000, 26'h10, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0, 32'h3008, 32'h3050));
    tbl.push_back(mk("gez_0",  3'd1, 3'd5, 32'h3000, 26'h10, 32'h0,         32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("gez_p1", 3'd1, 3'd5, 32'h3000, 26'h10, 32'h1,         32'd7, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("cmp6",   3'd1, 3'd6, 32'h3000, 26'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3008, 32'h3048));
    tbl.push_back(mk("cmp7",   3'd1, 3'd7, 32'h3000, 26'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3008, 32'h304C));
    tbl.push_back(mk("gtz_min", 3'd1, 3'd3, 32'h3000, 26'h10, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'h3008, 32'h3050));
    tbl.push_back(mk("gez_max", 3'd1, 3'd5, 32'h3000, 26'h10, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("lez_min", 3'd1, 3'd2, 32'h3000, 26'h10, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("beq_hi_imm", 3'd1, 3'd0, 32'h3000, 26'h3FF0010, 32'd9, 32'd9, 1'b1, 1'b0, 32'h3008, 32'h3044));
    tbl.push_back(mk("jump", 3'd2, 3'd0, 32'h3010, 26'h0000C40, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3018, 32'h3100));
    tbl.push_back(mk("jr", 3'd3, 3'd0, 32'h0, 26'h0, 32'h0000_3ABC, 32'h0, 1'b1, 1'b0, 32'h8, 32'h3ABC));
    tbl.push_back(mk("rsv5", 3'd5, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h3AC0));
    tbl.push_back(mk("rsv7", 3'd7, 3'd0, 32'h0, 26'h0, 32'h4, 32'h4, 1'b0, 1'b1, 32'h8, 32'h3AC4));
    tbl.push_back(mk("pc8_wrap", 3'd0, 3'd0, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h3AC8));
    tbl.push_back(mk("jr_limit", 3'd3, 3'd0, 32'h0, 26'h0, 32'h0000_6FFC, 32'h0, 1'b1, 1'b0, 32'h8, 32'h6FFC));

    // Reset state
    v = mk("reset", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h3000);
    v.reset = 1'b1;
    apply(v);
    apply(v);

    foreach (tbl[i]) apply(tbl[i]);

    // Stall holds F_pc even with a taken jump in D.
    v = mk("stall_a", 3'd2, 3'd0, 32'h3010, 26'h0000C40, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3018, 32'h6FFC);
    v.stall = 1'b1;
    apply(v);
    v.name = "stall_b";
    apply(v);
    // Flush wins over stall.
    v.name = "stall_flush"; v.flush = 1'b1; v.flush_pc = 32'h4180; v.exp_fpc = 32'h4180;
    apply(v);
    // Reset wins over flush.
    v.name = "reset_flush"; v.reset = 1'b1; v.stall = 1'b0; v.exp_fpc = 32'h3000;
    apply(v);
    // Released stall: the jump still in D now takes effect.
    v = mk("unstall_jump", 3'd2, 3'd0, 32'h3010, 26'h0000C40, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3018, 32'h3100);
    apply(v);

    // Range-check corners.
    v = mk("jr_misalign", 3'd3, 3'd0, 32'h0, 26'h0, 32'h0000_3002, 32'h0, 1'b1, 1'b0, 32'h8, 32'h3002);
`ifdef PC_RANGE_CHECK_EN
    v.exp_fpc = 32'h4180; v.exp_exc = 1'b1;
`endif
    apply(v);
    dn = v.exp_fpc + 32'd4;
    apply(mk("after_misalign", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, dn));

    v = mk("jr_above", 3'd3, 3'd0, 32'h0, 26'h0, 32'h0000_7000, 32'h0, 1'b1, 1'b0, 32'h8, 32'h7000);
`ifdef PC_RANGE_CHECK_EN
    v.exp_fpc = 32'h4180; v.exp_exc = 1'b1;
`endif
    apply(v);
    dn = v.exp_fpc + 32'd4;
    apply(mk("after_above", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, dn));

    // Flush target is taken as-is, even if misaligned.
    v = mk("flush_bypass", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0000_3002);
    v.flush = 1'b1; v.flush_pc = 32'h0000_3002;
    apply(v);

    // Sequential wrap-around from the top of the address space.
    v = mk("flush_top", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'hFFFF_FFFC);
    v.flush = 1'b1; v.flush_pc = 32'hFFFF_FFFC;
    apply(v);
    v = mk("wrap", 3'd0, 3'd0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0);
`ifdef PC_RANGE_CHECK_EN
    v.exp_fpc = 32'h4180; v.exp_exc = 1'b1;
`endif
    apply(v);

    // Jump keeps D_pc[31:28].
    v = mk("jump_hi", 3'd2, 3'd0, 32'hF000_0000, 26'h3FF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF000_0008, 32'hFFFF_FFFC);
`ifdef PC_RANGE_CHECK_EN
    v.exp_fpc = 32'h4180; v.exp_exc = 1'b1;
`endif
    apply(v);

    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
